// File: rtl/branch_recovery_ctrl_pkg.sv
// Shared definitions for branch recovery sequencing.
// Holds the recovery FSM encoding and the architectural PC width.
// Also imported by fetch and the issue window so both agree on state and PC sizing.
package branch_recovery_ctrl_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        FLUSH  = 2'd2,
        REFILL = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Generic saturating up-counter.
// Latency: count reflects an increment one cycle after inc is sampled.
// No backpressure: inc is ignored once the count is all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Sequences pipeline recovery after a committed control-flow redirect.
// Latency: commit at T -> flush/redirect at T+2 (DU idle), Stall released at T+3+REFILL_CYCLES.
// Backpressure: holds commits during DRAIN/FLUSH and stalls dispatch until back in IDLE.
module branch_recovery_ctrl
    import branch_recovery_ctrl_pkg::*;
#(
    parameter int REFILL_CYCLES = 2,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Commit_1,
    input  logic             Commit_1_Branch,
    input  logic [PC_W-1:0]  Commit_1_Branch_PC,
    input  logic             Issue_window_full,
    input  logic             DU_busy,
    input  logic             Ext_Stall,
    output logic             flush,
    output logic             Stall,
    output logic             Commit_hold,
    output logic             Redirect_valid,
    output logic [PC_W-1:0]  Redirect_PC,
    output logic             Drain_timeout,
    output logic [CNT_W-1:0] Flush_count
);

    localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int RW = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_TIMEOUT - 1);
    // Refill down-counter is loaded with N-1 so REFILL lasts exactly N cycles
    localparam logic [RW-1:0] REFILL_LOAD = RW'((REFILL_CYCLES > 0) ? (REFILL_CYCLES - 1) : 0);

    state_t          state;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] redirect_pc_q;
    logic [DW-1:0]   drain_timer;
    logic [RW-1:0]   refill_cnt;
    logic            drain_to_q;

    // Recovery FSM with its target capture, drain timer and refill timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            target        <= '0;
            redirect_pc_q <= '0;
            drain_timer   <= '0;
            refill_cnt    <= '0;
            drain_to_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A branch flag without a real commit is not a retirement
                    if (Commit_1 && Commit_1_Branch) begin
                        target      <= Commit_1_Branch_PC;
                        drain_timer <= '0;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Redirect_PC only moves on the way into FLUSH so it holds otherwise
                    if (!DU_busy) begin
                        redirect_pc_q <= target;
                        state         <= FLUSH;
                    end else if (drain_timer == DRAIN_LAST) begin
                        redirect_pc_q <= target;
                        drain_to_q    <= 1'b1;
                        state         <= FLUSH;
                    end else begin
                        drain_timer <= drain_timer + 1'b1;
                    end
                end
                FLUSH: begin
                    if (REFILL_CYCLES > 0) begin
                        refill_cnt <= REFILL_LOAD;
                        state      <= REFILL;
                    end else begin
                        state <= IDLE;
                    end
                end
                REFILL: begin
                    if (refill_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        refill_cnt <= refill_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Recovery events, saturating rather than wrapping
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (state == FLUSH),
        .count (Flush_count)
    );

    // Strobes decode from registered state only; Stall alone mixes in inputs
    assign flush          = (state == FLUSH);
    assign Redirect_valid = (state == FLUSH);
    assign Commit_hold    = (state == DRAIN) || (state == FLUSH);
    assign Redirect_PC    = redirect_pc_q;
    assign Drain_timeout  = drain_to_q;
    assign Stall          = Issue_window_full || Ext_Stall || (state != IDLE);

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
module tb_branch_recovery_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        Commit_1;
    logic        Commit_1_Branch;
    logic [31:0] Commit_1_Branch_PC;
    logic        Issue_window_full;
    logic        DU_busy;
    logic        Ext_Stall;

    // Main instance: default parameters
    logic        flush, Stall, Commit_hold, Redirect_valid, Drain_timeout;
    logic [31:0] Redirect_PC;
    logic [15:0] Flush_count;

    // Small instance: short drain timeout, 2-bit counter
    logic        flush_s, Stall_s, Commit_hold_s, Redirect_valid_s, Drain_timeout_s;
    logic [31:0] Redirect_PC_s;
    logic [1:0]  Flush_count_s;

    int asserts  = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_recovery_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .Commit_1           (Commit_1),
        .Commit_1_Branch    (Commit_1_Branch),
        .Commit_1_Branch_PC (Commit_1_Branch_PC),
        .Issue_window_full  (Issue_window_full),
        .DU_busy            (DU_busy),
        .Ext_Stall          (Ext_Stall),
        .flush              (flush),
        .Stall              (Stall),
        .Commit_hold        (Commit_hold),
        .Redirect_valid     (Redirect_valid),
        .Redirect_PC        (Redirect_PC),
        .Drain_timeout      (Drain_timeout),
        .Flush_count        (Flush_count)
    );

    branch_recovery_ctrl #(
        .REFILL_CYCLES (2),
        .DRAIN_TIMEOUT (4),
        .CNT_W         (2)
    ) dut_s (
        .clk                (clk),
        .rst                (rst),
        .Commit_1           (Commit_1),
        .Commit_1_Branch    (Commit_1_Branch),
        .Commit_1_Branch_PC (Commit_1_Branch_PC),
        .Issue_window_full  (Issue_window_full),
        .DU_busy            (DU_busy),
        .Ext_Stall          (Ext_Stall),
        .flush              (flush_s),
        .Stall              (Stall_s),
        .Commit_hold        (Commit_hold_s),
        .Redirect_valid     (Redirect_valid_s),
        .Redirect_PC        (Redirect_PC_s),
        .Drain_timeout      (Drain_timeout_s),
        .Flush_count        (Flush_count_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Commit_1           = 1'b0;
        Commit_1_Branch    = 1'b0;
        Commit_1_Branch_PC = 32'h0;
        Issue_window_full  = 1'b0;
        DU_busy            = 1'b0;
        Ext_Stall          = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic branch(input logic [31:0] pc);
        Commit_1           = 1'b1;
        Commit_1_Branch    = 1'b1;
        Commit_1_Branch_PC = pc;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        asserts++;
        if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
        asserts++;
        if (Stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", Stall); end
        asserts++;
        if (Flush_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Flush_count); end
        asserts++;
        if (Redirect_PC !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", Redirect_PC); end
        asserts++;
        if (Commit_hold !== 1'b0 || Drain_timeout !== 1'b0) begin
            failures++; $display("FAIL reset_hold_to got=%b%b exp=00", Commit_hold, Drain_timeout);
        end
    endtask

    task automatic test_basic();
        logic exp_hold, exp_flush, exp_stall;
        do_reset();
        branch(32'h0040_0100);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) clear_inputs();
            exp_hold  = (k == 1) || (k == 2);
            exp_flush = (k == 2);
            exp_stall = (k >= 1) && (k <= 4);
            asserts++;
            if (Commit_hold !== exp_hold) begin failures++; $display("FAIL basic_hold k=%0d got=%b exp=%b", k, Commit_hold, exp_hold); end
            asserts++;
            if (flush !== exp_flush || Redirect_valid !== exp_flush) begin
                failures++; $display("FAIL basic_flush k=%0d got=%b/%b exp=%b", k, flush, Redirect_valid, exp_flush);
            end
            asserts++;
            if (Stall !== exp_stall) begin failures++; $display("FAIL basic_stall k=%0d got=%b exp=%b", k, Stall, exp_stall); end
            if (k == 2) begin
                asserts++;
                if (Redirect_PC !== 32'h0040_0100) begin failures++; $display("FAIL basic_pc got=%h exp=00400100", Redirect_PC); end
            end
        end
        asserts++;
        if (Flush_count !== 16'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", Flush_count); end
    endtask

    task automatic test_drain_wait();
        do_reset();
        branch(32'h1234_5678);
        DU_busy = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                Commit_1 = 1'b0; Commit_1_Branch = 1'b0;
            end
            DU_busy = (k <= 5);
            asserts++;
            if (Commit_hold !== 1'b1) begin failures++; $display("FAIL drain_hold k=%0d got=%b exp=1", k, Commit_hold); end
            asserts++;
            if (flush !== (k == 7)) begin failures++; $display("FAIL drain_flush k=%0d got=%b exp=%b", k, flush, (k == 7)); end
        end
        asserts++;
        if (Redirect_PC !== 32'h1234_5678) begin failures++; $display("FAIL drain_pc got=%h exp=12345678", Redirect_PC); end
        asserts++;
        if (Drain_timeout !== 1'b0) begin failures++; $display("FAIL drain_to got=%b exp=0", Drain_timeout); end
    endtask

    task automatic test_timeout();
        do_reset();
        branch(32'hCAFE_0000);
        DU_busy = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin
                Commit_1 = 1'b0; Commit_1_Branch = 1'b0;
            end
            asserts++;
            if (flush_s !== (k == 5)) begin failures++; $display("FAIL tmo_flush k=%0d got=%b exp=%b", k, flush_s, (k == 5)); end
            asserts++;
            if (Drain_timeout_s !== (k == 5)) begin failures++; $display("FAIL tmo_flag k=%0d got=%b exp=%b", k, Drain_timeout_s, (k == 5)); end
        end
        asserts++;
        if (Redirect_PC_s !== 32'hCAFE_0000) begin failures++; $display("FAIL tmo_pc got=%h exp=cafe0000", Redirect_PC_s); end
        DU_busy = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        asserts++;
        if (Drain_timeout_s !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", Drain_timeout_s); end
        do_reset();
        asserts++;
        if (Drain_timeout_s !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", Drain_timeout_s); end
    endtask

    task automatic test_second_branch();
        int          nflush;
        logic [31:0] seen_pc;
        nflush  = 0;
        seen_pc = 32'h0;
        do_reset();
        branch(32'hAAAA_0000);
        DU_busy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) branch(32'hBBBB_0004);
            if (k == 2) clear_inputs();
            if (flush) begin
                nflush++;
                seen_pc = Redirect_PC;
            end
        end
        asserts++;
        if (nflush != 1) begin failures++; $display("FAIL second_nflush got=%0d exp=1", nflush); end
        asserts++;
        if (seen_pc !== 32'hAAAA_0000) begin failures++; $display("FAIL second_pc got=%h exp=aaaa0000", seen_pc); end
        asserts++;
        if (Stall !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b exp=0", Stall); end
        Issue_window_full = 1'b1;
        #1;
        asserts++;
        if (Stall !== 1'b1) begin failures++; $display("FAIL iwf_stall got=%b exp=1", Stall); end
        Issue_window_full = 1'b0;
        Ext_Stall = 1'b1;
        #1;
        asserts++;
        if (Stall !== 1'b1) begin failures++; $display("FAIL ext_stall got=%b exp=1", Stall); end
        Ext_Stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        branch(32'h0000_0C00);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) clear_inputs();
            if (k == 3) DU_busy = 1'b1;
            if (k == 4) DU_busy = 1'b0;
            if (k == 5) begin
                asserts++;
                if (Stall !== 1'b0) begin failures++; $display("FAIL b2b_idle_stall got=%b exp=0", Stall); end
                branch(32'h0000_0D00);
            end
            if (k == 6) begin
                asserts++;
                if (Commit_hold !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", Commit_hold); end
                clear_inputs();
            end
            if (k == 7) begin
                asserts++;
                if (flush !== 1'b1 || Redirect_PC !== 32'h0000_0D00) begin
                    failures++; $display("FAIL b2b_flush got=%b/%h exp=1/00000d00", flush, Redirect_PC);
                end
            end
        end
        asserts++;
        if (Flush_count !== 16'd2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", Flush_count); end
    endtask

    task automatic test_reset_refill_sat();
        do_reset();
        branch(32'h0000_1000);
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 1) clear_inputs();
        end
        asserts++;
        if (Stall !== 1'b1) begin failures++; $display("FAIL refill_stall got=%b exp=1", Stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        asserts++;
        if (Stall !== 1'b0 || Flush_count !== 16'd0) begin
            failures++; $display("FAIL refill_rst got=%b/%0d exp=0/0", Stall, Flush_count);
        end
        for (int i = 0; i < 5; i++) begin
            branch(32'h0000_2000 + 32'(i));
            tick();
            clear_inputs();
            for (int j = 0; j < 4; j++) tick();
        end
        asserts++;
        if (Flush_count_s !== 2'd3) begin failures++; $display("FAIL sat_count got=%0d exp=3", Flush_count_s); end
        asserts++;
        if (Flush_count !== 16'd5) begin failures++; $display("FAIL wide_count got=%0d exp=5", Flush_count); end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_basic();
        test_drain_wait();
        test_timeout();
        test_second_branch();
        test_back_to_back();
        test_reset_refill_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
